hdlc_tx_sequencer: RTL
======================

HDLC_TX_SEQUENCER -- requirements
Module: hdlc_tx_sequencer

Interface
REQ-001 SHALL have parameter IDLE_FLAGS, default 1, meaning: 1 = send 0x7E continuously while idle, 0 = serializer left unstrobed while idle.
REQ-002 SHALL have parameter FCS_EN, default 1, meaning: 1 = append a 2-byte FCS-16 before the closing flag.
REQ-003 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous, active-low reset.
REQ-004 SHALL have ports: frame_valid  in  1  frame pending; data_in  in  8  payload byte; data_valid  in  1  data_in valid; data_last  in  1  data_in is final payload byte; data_ready  out  1  payload byte consumed this cycle.
REQ-005 SHALL have ports: abort_req  in  1  abort current frame; ser_ready  in  1  serializer can accept a byte; ser_data  out  8  byte to serializer; ser_strobe  out  1  ser_data load pulse; ser_stuff  out  1  1 = bit-stuff this byte, 0 = send raw.
REQ-006 SHALL have ports: tx_busy  out  1  frame in progress; tx_done  out  1  frame completed pulse; tx_aborted  out  1  frame aborted pulse.

Function
REQ-007 Slot: a cycle with ser_ready=1 and ser_strobe=0 in the previous cycle; the block SHALL issue at most one byte per slot, registered, with ser_strobe high for exactly one cycle.
REQ-008 Data handshake: data_ready SHALL be combinational, high only in state DATA during a slot with data_valid=1; a byte transfers when data_valid & data_ready.
REQ-009 States SHALL be IDLE, OPEN, DATA, FCS_LO, FCS_HI, CLOSE, ABORT.
REQ-010 IDLE: with frame_valid=1 at a slot, SHALL strobe 0x7E (ser_stuff=0) and go to DATA (OPEN counts as this strobe); otherwise, if IDLE_FLAGS=1, SHALL strobe 0x7E each slot, else no strobe.
REQ-011 DATA: each slot with data_valid=1, SHALL strobe data_in with ser_stuff=1 and update the FCS; if data_last=1, go to FCS_LO (FCS_EN=1) or CLOSE (FCS_EN=0).
REQ-012 DATA underrun: a slot with data_valid=0 SHALL go to ABORT without strobing.
REQ-013 FCS: CRC-16/X.25 -- reflected polynomial 0x8408, init 0xFFFF, computed LSB-first over payload bytes only, result complemented; FCS_LO SHALL send the low byte, FCS_HI the high byte, both with ser_stuff=1.
REQ-014 CLOSE: SHALL strobe 0x7E with ser_stuff=0, pulse tx_done in the same cycle, reinitialise the FCS to 0xFFFF, and return to IDLE.
REQ-015 ABORT: at the next slot SHALL strobe 0xFF with ser_stuff=0, pulse tx_aborted in the same cycle, reinitialise the FCS, and return to IDLE.
REQ-016 abort_req=1 in DATA, FCS_LO, FCS_HI or CLOSE SHALL take priority over that cycle's normal transfer (no data_ready, no strobe) and go to ABORT; abort_req SHALL be ignored in IDLE and ABORT.
REQ-017 A closing flag SHALL NOT double as the next opening flag: every frame gets its own opening 0x7E.
REQ-018 tx_busy SHALL be 1 in every state except IDLE.
REQ-019 frame_valid SHALL only be sampled in IDLE; a deassertion mid-frame SHALL have no effect.
REQ-020 ser_data SHALL hold its last value between strobes.

Reset
REQ-021 When reset=0 at a clk rising edge, SHALL enter IDLE with ser_strobe=0, ser_stuff=0, ser_data=0x7E, data_ready=0, tx_busy=0, tx_done=0, tx_aborted=0, FCS=0xFFFF, and the previous-strobe flag cleared.
REQ-022 Reset mid-frame SHALL discard the frame with no abort byte and no tx_aborted pulse; the first slot after release SHALL follow IDLE rules.

Verification
REQ-023 Serializer model with ser_ready held 1 and deasserting for 8 cycles after each strobe; frame "123456789" (ASCII), FCS_EN=1 -> bytes 7E 31..39 6E 90 7E, stuff flags 0,1x11,0, one tx_done pulse.
REQ-024 FCS_EN=0, single byte 0x7E with data_last=1 -> bytes 7E 7E 7E, ser_stuff 0,1,0; tx_done once.
REQ-025 data_valid dropped after the 2nd payload byte -> bytes 7E b0 b1 FF, last byte with ser_stuff=0, tx_aborted once, no tx_done, then idle flags.
REQ-026 abort_req pulsed in FCS_HI -> no FCS high byte, next strobe 0xFF, tx_aborted=1; abort_req pulsed in IDLE -> no effect.
REQ-027 IDLE_FLAGS=0 with no frame -> zero strobes over 100 cycles; IDLE_FLAGS=1 -> one 0x7E per slot, never two strobes in adjacent cycles.
REQ-028 reset=0 for one cycle mid-payload -> all outputs at REQ-021 values next cycle, no 0xFF sent, next frame FCS correct.

Source files
------------

// File: rtl/hdlc_tx_sequencer.sv
// HDLC transmit sequencer: wraps a payload stream in 0x7E flags, an optional CRC-16/X.25 FCS, or an 0xFF abort.
// One registered byte per serializer slot (ser_ready with no strobe last cycle); data_ready is combinational.
module hdlc_tx_sequencer #(
    parameter bit IDLE_FLAGS = 1'b1,
    parameter bit FCS_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_valid,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       data_last,
    output logic       data_ready,
    input  logic       abort_req,
    input  logic       ser_ready,
    output logic [7:0] ser_data,
    output logic       ser_strobe,
    output logic       ser_stuff,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_aborted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPEN,
        S_DATA,
        S_FCS_LO,
        S_FCS_HI,
        S_CLOSE,
        S_ABORT
    } state_t;

    localparam logic [7:0]  FLAG_BYTE  = 8'h7E;
    localparam logic [7:0]  ABORT_BYTE = 8'hFF;
    localparam logic [15:0] FCS_INIT   = 16'hFFFF;

    state_t      state_q, state_d;
    logic [15:0] fcs_q, fcs_d;
    logic [7:0]  ser_data_q, ser_data_d;
    logic        ser_strobe_q, ser_strobe_d;
    logic        ser_stuff_q, ser_stuff_d;
    logic        tx_done_q, tx_done_d;
    logic        tx_aborted_q, tx_aborted_d;
    logic        slot;

    // Reflected CRC-16 (poly 0x8408), one byte consumed LSB first.
    function automatic logic [15:0] fcs_update(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) begin
                c = (c >> 1) ^ 16'h8408;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // The strobe register doubles as the previous-strobe flag, so strobes can never be adjacent.
    assign slot       = ser_ready & ~ser_strobe_q;
    assign tx_busy    = (state_q != S_IDLE);
    assign data_ready = (state_q == S_DATA) & slot & data_valid & ~abort_req;

    always_comb begin
        state_d      = state_q;
        fcs_d        = fcs_q;
        ser_data_d   = ser_data_q;
        ser_stuff_d  = ser_stuff_q;
        ser_strobe_d = 1'b0;
        tx_done_d    = 1'b0;
        tx_aborted_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (slot && (frame_valid || IDLE_FLAGS)) begin
                    ser_strobe_d = 1'b1;
                    ser_data_d   = FLAG_BYTE;
                    ser_stuff_d  = 1'b0;
                    if (frame_valid) begin
                        state_d = S_DATA;
                    end
                end
            end
            S_OPEN: begin
                if (abort_req) begin
                    state_d = S_ABORT;
                end else if (slot) begin
                    ser_strobe_d = 1'b1;
                    ser_data_d   = FLAG_BYTE;
                    ser_stuff_d  = 1'b0;
                    state_d      = S_DATA;
                end
            end
            S_DATA: begin
                if (abort_req) begin
                    state_d = S_ABORT;
                end else if (slot) begin
                    if (data_valid) begin
                        ser_strobe_d = 1'b1;
                        ser_data_d   = data_in;
                        ser_stuff_d  = 1'b1;
                        fcs_d        = fcs_update(fcs_q, data_in);
                        if (data_last) begin
                            state_d = FCS_EN ? S_FCS_LO : S_CLOSE;
                        end
                    end else begin
                        // Source ran dry mid-frame: the frame cannot be completed.
                        state_d = S_ABORT;
                    end
                end
            end
            S_FCS_LO: begin
                if (abort_req) begin
                    state_d = S_ABORT;
                end else if (slot) begin
                    ser_strobe_d = 1'b1;
                    ser_data_d   = ~fcs_q[7:0];
                    ser_stuff_d  = 1'b1;
                    state_d      = S_FCS_HI;
                end
            end
            S_FCS_HI: begin
                if (abort_req) begin
                    state_d = S_ABORT;
                end else if (slot) begin
                    ser_strobe_d = 1'b1;
                    ser_data_d   = ~fcs_q[15:8];
                    ser_stuff_d  = 1'b1;
                    state_d      = S_CLOSE;
                end
            end
            S_CLOSE: begin
                if (abort_req) begin
                    state_d = S_ABORT;
                end else if (slot) begin
                    ser_strobe_d = 1'b1;
                    ser_data_d   = FLAG_BYTE;
                    ser_stuff_d  = 1'b0;
                    tx_done_d    = 1'b1;
                    fcs_d        = FCS_INIT;
                    state_d      = S_IDLE;
                end
            end
            S_ABORT: begin
                if (slot) begin
                    ser_strobe_d = 1'b1;
                    ser_data_d   = ABORT_BYTE;
                    ser_stuff_d  = 1'b0;
                    tx_aborted_d = 1'b1;
                    fcs_d        = FCS_INIT;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            fcs_q        <= FCS_INIT;
            ser_data_q   <= FLAG_BYTE;
            ser_strobe_q <= 1'b0;
            ser_stuff_q  <= 1'b0;
            tx_done_q    <= 1'b0;
            tx_aborted_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fcs_q        <= fcs_d;
            ser_data_q   <= ser_data_d;
            ser_strobe_q <= ser_strobe_d;
            ser_stuff_q  <= ser_stuff_d;
            tx_done_q    <= tx_done_d;
            tx_aborted_q <= tx_aborted_d;
        end
    end

    assign ser_data   = ser_data_q;
    assign ser_strobe = ser_strobe_q;
    assign ser_stuff  = ser_stuff_q;
    assign tx_done    = tx_done_q;
    assign tx_aborted = tx_aborted_q;

endmodule
